// File: rtl/host_stream_bridge.sv
// Purpose: host wire-endpoint <-> emulator stream bridge; seq/ack handshake to valid/ready, per-channel out FIFOs. Optional HOST_BRIDGE_BEAT_COUNTERS_EN adds beat_count.
// Latency: in-beat valid 1 cycle after seq change, ack 1 cycle after handshake; out data/count/pop_ack visible 1 cycle after push/pop.
// Backpressure: in-channel holds valid until ready; out-channel ready drops when FIFO full; host pops on empty are flagged, never stall.

// Purpose: small synchronous FIFO with occupancy count and zeroed head when empty.
// Latency: push/pop reflected in count and rd_dat on the cycle after the edge.
// Backpressure: caller must not push when full or pop when empty.
module host_stream_bridge_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_dat,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    // Storage array; contents need no reset because the count gates the head.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign rd_dat = empty ? '0 : mem[rd_ptr];
    assign count  = cnt;
endmodule

// Purpose: bridge top; NUM_IN seq-driven input channels, NUM_OUT FIFO-buffered output channels, sticky error flags.
// Latency: 1 cycle seq-change to valid; min 2 cycles between beats on one input channel; 1 pop per cycle per output channel.
// Backpressure: dut_in_valid held until dut_in_ready; dut_out_ready = FIFO not full (held low during and right after reset).
module host_stream_bridge #(
    parameter int NUM_IN     = 3,
    parameter int NUM_OUT    = 1,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUM_IN*DATA_W-1:0]                      host_in_data,
    input  logic [NUM_IN*SEQ_W-1:0]                       host_in_seq,
    output logic [NUM_IN*SEQ_W-1:0]                       host_in_ack,
    output logic [NUM_IN-1:0]                             dut_in_valid,
    input  logic [NUM_IN-1:0]                             dut_in_ready,
    output logic [NUM_IN*DATA_W-1:0]                      dut_in_bits,
    input  logic [NUM_OUT-1:0]                            dut_out_valid,
    output logic [NUM_OUT-1:0]                            dut_out_ready,
    input  logic [NUM_OUT*DATA_W-1:0]                     dut_out_bits,
    output logic [NUM_OUT*DATA_W-1:0]                     host_out_data,
    output logic [NUM_OUT*($clog2(FIFO_DEPTH)+1)-1:0]     host_out_count,
    input  logic [NUM_OUT*SEQ_W-1:0]                      host_out_pop_seq,
    output logic [NUM_OUT*SEQ_W-1:0]                      host_out_pop_ack,
    output logic [2:0]                                    err,
    input  logic                                          err_clr
`ifdef HOST_BRIDGE_BEAT_COUNTERS_EN
    ,
    output logic [(NUM_IN+NUM_OUT)*32-1:0]                beat_count
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [NUM_IN-1:0]  in_ovr;
    logic [NUM_OUT-1:0] out_udf;
    logic               out_en;
    logic [1:0]         err_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        logic [0:0]        state;
        logic [DATA_W-1:0] cap_dat;
        logic [SEQ_W-1:0]  cap_seq;
        logic [SEQ_W-1:0]  ack_seq;
        logic [SEQ_W-1:0]  cmd_seq;

        assign cmd_seq = host_in_seq[i*SEQ_W +: SEQ_W];

        // Capture a new command when seq differs from ack, then hold it until the DUT takes it.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state   <= ST_IDLE;
                cap_dat <= '0;
                cap_seq <= '0;
                ack_seq <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_seq != ack_seq) begin
                            cap_dat <= host_in_data[i*DATA_W +: DATA_W];
                            cap_seq <= cmd_seq;
                            state   <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (dut_in_ready[i]) begin
                            ack_seq <= cap_seq;
                            state   <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign dut_in_valid[i]                  = (state == ST_SEND);
        assign dut_in_bits[i*DATA_W +: DATA_W]  = cap_dat;
        assign host_in_ack[i*SEQ_W +: SEQ_W]    = ack_seq;
        // Host moved on before the held beat was taken: that command slot is overrun.
        assign in_ovr[i] = (state == ST_SEND) && (cmd_seq != cap_seq);
    end

    // Keeps dut_out_ready low while in reset and for the first cycle after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) out_en <= 1'b0;
        else        out_en <= 1'b1;
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        logic [SEQ_W-1:0]  pop_seq;
        logic [SEQ_W-1:0]  pop_ack;
        logic              pend;
        logic              push;
        logic              pop;
        logic              full;
        logic              empty;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] head;

        assign pop_seq          = host_out_pop_seq[j*SEQ_W +: SEQ_W];
        assign pend             = (pop_seq != pop_ack);
        assign dut_out_ready[j] = out_en & ~full;
        assign push             = dut_out_valid[j] & dut_out_ready[j];
        assign pop              = pend & ~empty;
        assign out_udf[j]       = pend & empty;

        // Every pending pop request is acknowledged, even on empty, so the host never hangs.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)    pop_ack <= '0;
            else if (pend) pop_ack <= pop_ack + 1'b1;
        end

        host_stream_bridge_fifo #(
            .W     (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock  (clock),
            .reset  (reset),
            .push   (push),
            .pop    (pop),
            .wr_dat (dut_out_bits[j*DATA_W +: DATA_W]),
            .rd_dat (head),
            .count  (cnt),
            .full   (full),
            .empty  (empty)
        );

        assign host_out_data[j*DATA_W +: DATA_W]  = head;
        assign host_out_count[j*CNT_W +: CNT_W]   = cnt;
        assign host_out_pop_ack[j*SEQ_W +: SEQ_W] = pop_ack;
    end

    // Sticky error flags; a clear in the same cycle as a new event wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       err_q <= '0;
        else if (err_clr) err_q <= '0;
        else              err_q <= err_q | {|out_udf, |in_ovr};
    end

    assign err = {1'b0, err_q};

`ifdef HOST_BRIDGE_BEAT_COUNTERS_EN
    for (genvar i = 0; i < NUM_IN; i++) begin : g_in_cnt
        logic [31:0] bc;
        // Free-running count of accepted input beats.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)                              bc <= '0;
            else if (dut_in_valid[i] & dut_in_ready[i]) bc <= bc + 32'd1;
        end
        assign beat_count[i*32 +: 32] = bc;
    end
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out_cnt
        logic [31:0] bc;
        // Free-running count of beats pushed into the output FIFO.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)                                  bc <= '0;
            else if (dut_out_valid[j] & dut_out_ready[j]) bc <= bc + 32'd1;
        end
        assign beat_count[(NUM_IN+j)*32 +: 32] = bc;
    end
`endif
endmodule

// File: tb/tb_host_stream_bridge.sv
// Directed bench for host_stream_bridge at default parameters.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants and simple loop bookkeeping.
module tb_host_stream_bridge;
    localparam int NI = 3, NO = 1, DW = 16, FD = 4, SW = 8, CW = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic [NI*DW-1:0]   host_in_data;
    logic [NI*SW-1:0]   host_in_seq;
    logic [NI*SW-1:0]   host_in_ack;
    logic [NI-1:0]      dut_in_valid;
    logic [NI-1:0]      dut_in_ready;
    logic [NI*DW-1:0]   dut_in_bits;
    logic [NO-1:0]      dut_out_valid;
    logic [NO-1:0]      dut_out_ready;
    logic [NO*DW-1:0]   dut_out_bits;
    logic [NO*DW-1:0]   host_out_data;
    logic [NO*CW-1:0]   host_out_count;
    logic [NO*SW-1:0]   host_out_pop_seq;
    logic [NO*SW-1:0]   host_out_pop_ack;
    logic [2:0]         err;
    logic               err_clr;
`ifdef HOST_BRIDGE_BEAT_COUNTERS_EN
    logic [(NI+NO)*32-1:0] beat_count;
`endif

    host_stream_bridge #(
        .NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .FIFO_DEPTH(FD), .SEQ_W(SW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .host_in_data     (host_in_data),
        .host_in_seq      (host_in_seq),
        .host_in_ack      (host_in_ack),
        .dut_in_valid     (dut_in_valid),
        .dut_in_ready     (dut_in_ready),
        .dut_in_bits      (dut_in_bits),
        .dut_out_valid    (dut_out_valid),
        .dut_out_ready    (dut_out_ready),
        .dut_out_bits     (dut_out_bits),
        .host_out_data    (host_out_data),
        .host_out_count   (host_out_count),
        .host_out_pop_seq (host_out_pop_seq),
        .host_out_pop_ack (host_out_pop_ack),
        .err              (err),
        .err_clr          (err_clr)
`ifdef HOST_BRIDGE_BEAT_COUNTERS_EN
        ,
        .beat_count       (beat_count)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int good1   = 0;
    int good2   = 0;
    logic [7:0]  s;
    logic [15:0] d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        host_in_data = '0; host_in_seq = '0; dut_in_ready = '0;
        dut_out_valid = '0; dut_out_bits = '0; host_out_pop_seq = '0; err_clr = 1'b0;
        tick(2);
        chk("rst_valid", dut_in_valid, 0);
        chk("rst_bits", dut_in_bits, 0);
        chk("rst_ack", host_in_ack, 0);
        chk("rst_oready", dut_out_ready, 0);
        chk("rst_odata", host_out_data, 0);
        chk("rst_ocount", host_out_count, 0);
        chk("rst_popack", host_out_pop_ack, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        tick(1);
        chk("post_rst_oready", dut_out_ready, 1);

        // Channel 0 single beat
        host_in_data[15:0] = 16'h1234; host_in_seq[7:0] = 8'd1; dut_in_ready[0] = 1'b1;
        tick(1);
        chk("c0_valid_up", dut_in_valid[0], 1);
        chk("c0_bits", dut_in_bits[15:0], 16'h1234);
        chk("c0_ack_pre", host_in_ack[7:0], 0);
        tick(1);
        chk("c0_valid_dn", dut_in_valid[0], 0);
        chk("c0_ack", host_in_ack[7:0], 1);
        chk("c0_err", err, 0);

        // Channel 1 stalled, overrun while sending
        dut_in_ready[1] = 1'b0; host_in_data[31:16] = 16'h1111; host_in_seq[15:8] = 8'd1;
        tick(1);
        chk("c1_valid_up", dut_in_valid[1], 1);
        chk("c1_bits1", dut_in_bits[31:16], 16'h1111);
        tick(3);
        host_in_data[31:16] = 16'h2222; host_in_seq[15:8] = 8'd2;
        tick(1);
        chk("c1_ovr_err", err, 3'b001);
        tick(6);
        chk("c1_hold_valid", dut_in_valid[1], 1);
        chk("c1_hold_bits", dut_in_bits[31:16], 16'h1111);
        chk("c1_hold_ack", host_in_ack[15:8], 0);
        dut_in_ready[1] = 1'b1;
        tick(1);
        chk("c1_beat1_done", dut_in_valid[1], 0);
        chk("c1_ack1", host_in_ack[15:8], 1);
        tick(1);
        chk("c1_beat2_valid", dut_in_valid[1], 1);
        chk("c1_beat2_bits", dut_in_bits[31:16], 16'h2222);
        tick(1);
        chk("c1_ack2", host_in_ack[15:8], 2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("c1_err_clr", err, 0);

        // Channel 2: clear beats a same-cycle overrun set
        dut_in_ready[2] = 1'b0; host_in_data[47:32] = 16'h3333; host_in_seq[23:16] = 8'd1;
        tick(1);
        host_in_seq[23:16] = 8'd2; err_clr = 1'b1;
        tick(1);
        chk("clr_wins", err, 0);
        err_clr = 1'b0;
        tick(1);
        chk("ovr_after_clr", err, 3'b001);
        dut_in_ready[2] = 1'b1;
        tick(3);
        chk("c2_ack2", host_in_ack[23:16], 2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("c2_err_clr", err, 0);

        // Output FIFO fill to full, then one pop frees a slot
        dut_out_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dut_out_bits = 16'hA0 + 16'(k);
            tick(1);
        end
        chk("fifo_full_cnt", host_out_count, 4);
        chk("fifo_full_rdy", dut_out_ready, 0);
        chk("fifo_head_a0", host_out_data, 16'hA0);
        dut_out_bits = 16'hA4;
        tick(2);
        chk("fifo_blocked_cnt", host_out_count, 4);
        host_out_pop_seq = 8'd1;
        tick(1);
        chk("pop1_head", host_out_data, 16'hA1);
        chk("pop1_cnt", host_out_count, 3);
        chk("pop1_rdy", dut_out_ready, 1);
        chk("pop1_ack", host_out_pop_ack, 1);
        tick(1);
        chk("fifth_push_cnt", host_out_count, 4);
        dut_out_valid[0] = 1'b0;
        host_out_pop_seq = 8'd5;
        tick(1);
        chk("drain_a2", host_out_data, 16'hA2);
        tick(1);
        chk("drain_a3", host_out_data, 16'hA3);
        tick(1);
        chk("drain_a4", host_out_data, 16'hA4);
        tick(1);
        chk("drain_empty_data", host_out_data, 0);
        chk("drain_empty_cnt", host_out_count, 0);
        chk("drain_popack", host_out_pop_ack, 5);
        chk("drain_err", err, 0);

        // Pops on empty FIFO
        host_out_pop_seq = 8'd8;
        tick(1);
        chk("udf_ack6", host_out_pop_ack, 6);
        chk("udf_err", err, 3'b010);
        tick(2);
        chk("udf_ack8", host_out_pop_ack, 8);
        chk("udf_cnt", host_out_count, 0);
        tick(1);
        chk("udf_ack_stop", host_out_pop_ack, 8);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("udf_clr", err, 0);

        // Simultaneous push and pop
        dut_out_valid[0] = 1'b1; dut_out_bits = 16'hA5;
        tick(1);
        dut_out_bits = 16'hA6;
        tick(1);
        chk("pp_cnt_pre", host_out_count, 2);
        dut_out_bits = 16'hA7; host_out_pop_seq = 8'd9;
        tick(1);
        chk("pp_cnt", host_out_count, 2);
        chk("pp_head", host_out_data, 16'hA6);
        chk("pp_ack", host_out_pop_ack, 9);
        dut_out_valid[0] = 1'b0;

        // Sequence wrap on channel 0: 300 commands
        for (int n = 2; n <= 301; n++) begin
            s = n[7:0];
            d = 16'(n * 7 + 3);
            host_in_data[15:0] = d; host_in_seq[7:0] = s;
            tick(1);
            if (dut_in_valid[0] && dut_in_bits[15:0] == d) good1++;
            tick(1);
            if (!dut_in_valid[0] && host_in_ack[7:0] == s) good2++;
        end
        chk("wrap_beats", good1, 300);
        chk("wrap_acks", good2, 300);
        chk("wrap_final_ack", host_in_ack[7:0], 8'd45);
        chk("wrap_other_ack", host_in_ack[15:8], 2);
        chk("wrap_err", err, 0);

        // Asynchronous reset mid-SEND with two FIFO entries
        dut_in_ready[1] = 1'b0; host_in_data[31:16] = 16'hBEEF; host_in_seq[15:8] = 8'd3;
        tick(1);
        chk("pre_rst_valid", dut_in_valid[1], 1);
        chk("pre_rst_cnt", host_out_count, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", dut_in_valid, 0);
        chk("arst_bits", dut_in_bits, 0);
        chk("arst_ack", host_in_ack, 0);
        chk("arst_oready", dut_out_ready, 0);
        chk("arst_odata", host_out_data, 0);
        chk("arst_cnt", host_out_count, 0);
        chk("arst_popack", host_out_pop_ack, 0);
        host_in_seq = '0; host_out_pop_seq = '0; host_in_data[31:16] = 16'hCAFE;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rel_oready", dut_out_ready, 1);
        chk("rel_valid", dut_in_valid, 0);
        host_in_seq[15:8] = 8'd1; dut_in_ready[1] = 1'b1;
        tick(1);
        chk("rel_c1_valid", dut_in_valid[1], 1);
        chk("rel_c1_bits", dut_in_bits[31:16], 16'hCAFE);
        tick(1);
        chk("rel_c1_ack", host_in_ack[15:8], 1);
        chk("rel_c1_done", dut_in_valid[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
